// File: rtl/mod_cpa_fsub_pkg.sv
// Shared constants for the carry-propagate / final-subtract stage of the
// modular reduction datapath: default widths and the modulus multiples used
// as subtraction and range-check thresholds.
package mod_cpa_fsub_pkg;

  // Default datapath widths.
  localparam int unsigned DEF_W     = 15;
  localparam int unsigned DEF_QW    = 12;
  localparam int unsigned DEF_TAG_W = 2;

  // Width of the resolved carry-save sum x = s + c (one carry bit of growth).
  localparam int unsigned MOD_XW = DEF_W + 1;

  // Modulus and its multiples at the resolved-sum width.
  localparam logic [MOD_XW-1:0] MOD_Q  = 16'd3329;
  localparam logic [MOD_XW-1:0] MOD_Q2 = 16'd6658;
  localparam logic [MOD_XW-1:0] MOD_Q4 = 16'd13316;

endpackage : mod_cpa_fsub_pkg

// File: rtl/mod_csub.sv
// Conditional subtract: y = (x >= K) ? x - K : x. Purely combinational; used
// once with K = 2Q and once with K = Q to fold x < 4Q down to x mod Q.
module mod_csub #(
  parameter int unsigned       XW = 16,
  parameter logic [XW-1:0]     K  = '0
) (
  input  logic [XW-1:0] i_x,
  output logic [XW-1:0] o_y
);

  logic w_ge;

  assign w_ge = (i_x >= K);
  assign o_y  = w_ge ? (i_x - K) : i_x;

endmodule : mod_csub

// File: rtl/mod_cpa_fsub.sv
// Resolves a carry-save (s, c) pair into x = s + c and reduces it to x mod Q
// through two conditional subtractions (2Q, then Q). Three-stage valid/ready
// pipeline with full-rate backpressure; a lane tag rides alongside the data.
// Optional build macro: MOD_RANGE_CHK_EN adds an x >= 4Q flag that travels
// with the item to out_err; without it out_err is tied low.
module mod_cpa_fsub
  import mod_cpa_fsub_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned Q     = 32'(MOD_Q),
  parameter int unsigned QW    = DEF_QW,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_s,
  input  logic [W-1:0]     in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned      XW   = W + 1;
  localparam logic [XW-1:0]    K_Q  = XW'(Q);
  localparam logic [XW-1:0]    K_2Q = XW'(2 * Q);

  // Stage registers.
  logic             r_v1, r_v2, r_v3;
  logic [XW-1:0]    r_x1, r_x2;
  logic [QW-1:0]    r_r3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;

  // Ready chain and combinational stage results.
  logic             w_rdy1, w_rdy2, w_rdy3;
  logic [XW-1:0]    w_x1, w_x2, w_x3;
  logic             w_unused_x3_hi;

  // A stage can accept when it is empty or its successor is taking its item.
  assign w_rdy3   = !r_v3 || out_ready;
  assign w_rdy2   = !r_v2 || w_rdy3;
  assign w_rdy1   = !r_v1 || w_rdy2;
  assign in_ready = w_rdy1;

  // Full-width add: no truncation of the carry out of the W-bit operands.
  assign w_x1 = {1'b0, in_s} + {1'b0, in_c};

  mod_csub #(.XW(XW), .K(K_2Q)) u_csub_2q (
    .i_x (r_x1),
    .o_y (w_x2)
  );

  mod_csub #(.XW(XW), .K(K_Q)) u_csub_q (
    .i_x (r_x2),
    .o_y (w_x3)
  );

  // Bits above QW are zero for in-range inputs and intentionally dropped.
  assign w_unused_x3_hi = ^w_x3[XW-1:QW];

  // Valid/data pipeline: each stage loads from its predecessor when its rdy is
  // high; data only moves with a valid item so held outputs stay stable.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset along with the valid bits so the
    // output port reads 0 after reset, not stale data from a discarded item.
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_r3   <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its predecessor's
      // pre-edge value, so the pipeline shifts as one in a single clock.
      if (w_rdy1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_x1   <= w_x1;
          r_tag1 <= in_tag;
        end
      end
      if (w_rdy2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_x2   <= w_x2;
          r_tag2 <= r_tag1;
        end
      end
      if (w_rdy3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_r3   <= w_x3[QW-1:0];
          r_tag3 <= r_tag2;
        end
      end
    end
  end

  assign out_valid = r_v3;
  assign out_r     = r_r3;
  assign out_tag   = r_tag3;

`ifdef MOD_RANGE_CHK_EN
  localparam logic [XW-1:0] K_4Q = XW'(4 * Q);

  logic r_err1, r_err2, r_err3;

  // Range-violation flag follows its item through the same load enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err1 <= 1'b0;
      r_err2 <= 1'b0;
      r_err3 <= 1'b0;
    end else begin
      if (w_rdy1 && in_valid) r_err1 <= (w_x1 >= K_4Q);
      if (w_rdy2 && r_v1)     r_err2 <= r_err1;
      if (w_rdy3 && r_v2)     r_err3 <= r_err2;
    end
  end

  assign out_err = r_err3;
`else
  assign out_err = 1'b0;
`endif

endmodule : mod_cpa_fsub

// File: tb/tb_mod_cpa_fsub.sv
// Self-checking bench for mod_cpa_fsub: table-driven boundary vectors, random
// back-to-back traffic, backpressure, mid-stream reset and the range flag.
// Expected results are queued when an input transfer is seen and compared
// when the output transfer is seen.
module tb_mod_cpa_fsub;

  localparam int Q = 3329;
`ifdef MOD_RANGE_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] r;
    logic [1:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [14:0] s;
    logic [14:0] c;
    logic [1:0]  tag;
    logic [11:0] exp_r;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_s;
  logic [14:0] in_c;
  logic [1:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_r;
  logic [1:0]  out_tag;
  logic        out_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;
  int   out_count  = 0;
  int   last_out_cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];

  mod_cpa_fsub dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_c      (in_c),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_r", int'(out_r), int'(mon_e.r));
        check("out_tag", int'(out_tag), int'(mon_e.tag));
        check("out_err", int'(out_err), int'(mon_e.err));
      end
      out_count++;
      last_out_cyc = cyc;
    end
  end

  // Offer one item; queue its expected result when the handshake is seen.
  task automatic send(input logic [14:0] s, input logic [14:0] c,
                      input logic [1:0] tag, input exp_t e);
    int waited = 0;
    in_valid = 1'b1;
    in_s     = s;
    in_c     = c;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        accept_cyc = cyc;
        break;
      end
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_x(input int x, input logic [1:0] tag);
    exp_t e;
    int   s;
    s     = int'($urandom_range(0, x));
    e.r   = 12'(x % Q);
    e.tag = tag;
    e.err = 1'b0;
    send(15'(s), 15'(x - s), tag, e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   cnt0;
    int   start_cyc;
    int   n;
    int   accepted;
    int   idx;
    int   xs[5];
    exp_t e;

    vecs[0] = '{s: 15'd0,     c: 15'd0,    tag: 2'd0, exp_r: 12'd0,    exp_err: 1'b0};
    vecs[1] = '{s: 15'd3000,  c: 15'd328,  tag: 2'd2, exp_r: 12'd3328, exp_err: 1'b0};
    vecs[2] = '{s: 15'd3329,  c: 15'd0,    tag: 2'd3, exp_r: 12'd0,    exp_err: 1'b0};
    vecs[3] = '{s: 15'd6000,  c: 15'd658,  tag: 2'd1, exp_r: 12'd0,    exp_err: 1'b0};
    vecs[4] = '{s: 15'd10000, c: 15'd3315, tag: 2'd2, exp_r: 12'd3328, exp_err: 1'b0};
    vecs[5] = '{s: 15'd13000, c: 15'd316,  tag: 2'd3, exp_r: 12'd3329, exp_err: ERR_EN};
    vecs[6] = '{s: 15'd7000,  c: 15'd6315, tag: 2'd0, exp_r: 12'd3328, exp_err: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_s      = '0;
    in_c      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_r", int'(out_r), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_out_err", int'(out_err), 0);
    @(posedge clk);
    #1;

    // Single item with latency measurement: 4095 + 256 = 4351 -> 1022.
    out_ready = 1'b1;
    e = '{r: 12'd1022, tag: 2'd1, err: 1'b0};
    send(15'd4095, 15'd256, 2'd1, e);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", cyc - accept_cyc, 3);
    wait_drain();

    // Boundary table.
    foreach (vecs[i]) begin
      e = '{r: vecs[i].exp_r, tag: vecs[i].tag, err: vecs[i].exp_err};
      send(vecs[i].s, vecs[i].c, vecs[i].tag, e);
    end
    wait_drain();

    // Back-to-back random traffic at full rate.
    cnt0 = out_count;
    n    = 0;
    send_x(int'($urandom_range(0, 4 * Q - 1)), 2'd0);
    start_cyc = accept_cyc;
    for (int i = 1; i < 16; i++) begin
      send_x(int'($urandom_range(0, 4 * Q - 1)), 2'(i));
      if (accept_cyc != start_cyc + i) n++;
    end
    check("b2b_input_stalls", n, 0);
    wait_drain();
    check("b2b_count", out_count - cnt0, 16);
    check("b2b_last_cycle", last_out_cyc - start_cyc, 18);

    // Backpressure: five items offered into a stalled pipeline.
    for (int i = 0; i < 5; i++) xs[i] = int'($urandom_range(0, 4 * Q - 1));
    cnt0      = out_count;
    out_ready = 1'b0;
    accepted  = 0;
    idx       = 0;
    in_valid  = 1'b1;
    in_s      = 15'(xs[0]);
    in_c      = '0;
    in_tag    = 2'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{r: 12'(xs[idx] % Q), tag: 2'(idx), err: 1'b0});
        idx++;
        accepted++;
      end
      @(posedge clk);
      #1;
      in_s   = 15'(xs[idx]);
      in_tag = 2'(idx);
    end
    check("bp_accepted", accepted, 3);
    @(negedge clk);
    check("bp_full_in_ready", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_hold_r", int'(out_r), int'(sb[0].r));
    check("bp_hold_tag", int'(out_tag), int'(sb[0].tag));
    @(posedge clk);
    #1;
    // Drain and refill in the same cycle.
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_refill_in_ready", int'(in_ready), 1);
    if (in_ready) begin
      sb.push_back('{r: 12'(xs[idx] % Q), tag: 2'(idx), err: 1'b0});
      idx++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (idx < 5) begin
      e = '{r: 12'(xs[idx] % Q), tag: 2'(idx), err: 1'b0};
      send(15'(xs[idx]), 15'd0, 2'(idx), e);
      idx++;
    end
    wait_drain();
    check("bp_total_out", out_count - cnt0, 5);

    // Mid-stream reset with two items in flight: they must never appear.
    send_x(1234, 2'd1);
    send_x(9999, 2'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    cnt0 = out_count;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_r", int'(out_r), 0);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", out_count - cnt0, 0);

    // Pipeline still works after reset.
    send_x(13315, 2'd3);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mod_cpa_fsub
